regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the processor's 32×32 register file: two registered read ports, one write port, write-to-read bypass, an optional hardwired-zero register, and a per-register busy scoreboard for pipeline hazard detection. It sits between the decode and writeback stages of the Turboencabulator core. Decode reads operands and busy flags here. Issue marks a destination register busy. Writeback updates the register and clears its busy flag.

## Interface
- DATA_WIDTH, default 32: bits per register.
- ADDR_WIDTH, default 5: register index width; depth = 2**ADDR_WIDTH.
- ZERO_REG, default 1: when 1, register 0 always reads 0, ignores writes and is never busy.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately when asserted.
- RegWrite  in  1  write enable.
- WriteRegister  in  ADDR_WIDTH  write index.
- WriteData  in  DATA_WIDTH  write value.
- SetBusy  in  1  mark SetBusyRegister busy (instruction issued).
- SetBusyRegister  in  ADDR_WIDTH  index to mark busy.
- ReadRegister1, ReadRegister2  in  ADDR_WIDTH  read indices.
- ReadData1, ReadData2  out  DATA_WIDTH  registered read data.
- ReadBusy1, ReadBusy2  out  1  registered busy flag of the corresponding read index.
- AnyBusy  out  1  OR of all busy bits, registered.

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, plus one busy bit per register.
- Reset: all registers are 0, all busy bits are 0, and all outputs are 0 while reset is high. The first capture happens at the first rising edge after reset deasserts. Reset mid-operation discards pending writes and busy marks.
- Write: at the rising edge with RegWrite=1, registers[WriteRegister] <= WriteData and busy[WriteRegister] <= 0.
- Set busy: at the rising edge with SetBusy=1, busy[SetBusyRegister] <= 1.
- Simultaneous SetBusy and RegWrite to the same index: the data is written and the busy bit ends at 1. A new producer issued in the same cycle as the old one retires wins.
- Read: at each rising edge, ReadDataN <= value of ReadRegisterN, and ReadBusyN <= busy of ReadRegisterN.
- Bypass: the read sees the post-edge state.
  - A write to the same index on the same edge returns WriteData.
  - ReadBusyN reflects the same set/clear resolution as the busy array. A write alone clears the bit; SetBusy alone or SetBusy plus write sets it.
- Both read ports may address the same register, including the one being written; both return identical results.
- ZERO_REG=1, index 0:
  - Writes are dropped and SetBusy is dropped.
  - ReadDataN=0 and ReadBusyN=0, with no bypass.
- ZERO_REG=0: register 0 behaves like every other register.
- AnyBusy: registered OR of the post-edge busy array.
- Indices are always in range, since the depth is a power of two. There are no error outputs.

## Timing
- Write-to-storage latency: 1 edge.
- Read latency: 1 cycle. An address presented before edge k produces data valid after edge k, stable until edge k+1.
- The write/read bypass adds no extra cycle. A value written at edge k is visible on a read sampled at edge k.
- Busy set/clear takes effect at the same edge as the request, and is visible on ReadBusyN and AnyBusy after that edge.
- Asynchronous reset forces outputs to 0 without waiting for clk. Deassertion is assumed synchronised upstream.
- No combinational path from any input to any output.

## Test plan
- Reset: fill r5=0xDEADBEEF, pulse reset between edges → ReadData1/2, ReadBusy1/2 and AnyBusy are 0 immediately. A following read of r5 returns 0x00000000.
- Write/read: write r7=0x12345678 at edge k, then read r7 on port 1 and r3 on port 2 at edge k+1 → ReadData1=0x12345678, ReadData2=0.
- Bypass: on the same edge, write r9=0xCAFEF00D and read r9 on both ports → both ReadData=0xCAFEF00D.
- Scoreboard:
  - SetBusy r4 → ReadBusy on r4=1 and AnyBusy=1.
  - Write r4=0x1 → ReadBusy=0 and AnyBusy=0.
  - SetBusy r4 together with a write to r4=0x2 → data reads 0x2 and ReadBusy=1.
- ZERO_REG=1: write r0=0xFFFFFFFF plus SetBusy r0 → ReadData=0, ReadBusy=0 and AnyBusy=0. With ZERO_REG=0, the same stimulus → reads 0xFFFFFFFF and busy=1.
- Parametrisation: run DATA_WIDTH=16, ADDR_WIDTH=3. Write all 8 registers with index×0x1111, then read them back. r7 reads 0x7777 and no aliasing occurs.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with two registered read
// ports, one write port, write-to-read bypass, an optional hardwired-zero
// register and a per-register busy scoreboard for hazard detection.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  SetBusy,
    input  logic [ADDR_WIDTH-1:0] SetBusyRegister,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadBusy1,
    output logic                  ReadBusy2,
    output logic                  AnyBusy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic                  writeEn;
    logic                  setEn;
    logic                  zeroRd1;
    logic                  zeroRd2;

    logic [DATA_WIDTH-1:0] readData1_d, readData1_q;
    logic [DATA_WIDTH-1:0] readData2_d, readData2_q;
    logic                  readBusy1_d, readBusy1_q;
    logic                  readBusy2_d, readBusy2_q;
    logic                  anyBusy_d,   anyBusy_q;

    // Qualify write and busy-set requests; index 0 swallows both when it is hardwired
    always_comb begin
        writeEn = RegWrite;
        setEn   = SetBusy;
        zeroRd1 = 1'b0;
        zeroRd2 = 1'b0;
        if (ZERO_REG) begin
            writeEn = RegWrite && (WriteRegister != '0);
            setEn   = SetBusy && (SetBusyRegister != '0);
            zeroRd1 = (ReadRegister1 == '0);
            zeroRd2 = (ReadRegister2 == '0);
        end
    end

    // Post-edge busy array: a write retires its producer, then a same-cycle issue re-marks it
    always_comb begin
        busy_d = busy_q;
        if (writeEn) begin
            busy_d[WriteRegister] = 1'b0;
        end
        if (setEn) begin
            busy_d[SetBusyRegister] = 1'b1;
        end
    end

    // Read values as they will look after this edge, with the write bypassed in
    always_comb begin
        readData1_d = regs_q[ReadRegister1];
        readData2_d = regs_q[ReadRegister2];
        if (writeEn && (WriteRegister == ReadRegister1)) begin
            readData1_d = WriteData;
        end
        if (writeEn && (WriteRegister == ReadRegister2)) begin
            readData2_d = WriteData;
        end
        readBusy1_d = busy_d[ReadRegister1];
        readBusy2_d = busy_d[ReadRegister2];
        if (zeroRd1) begin
            readData1_d = '0;
            readBusy1_d = 1'b0;
        end
        if (zeroRd2) begin
            readData2_d = '0;
            readBusy2_d = 1'b0;
        end
        anyBusy_d = |busy_d;
    end

    // Register storage and scoreboard; reset wipes everything, including pending marks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (writeEn) begin
                regs_q[WriteRegister] <= WriteData;
            end
            busy_q <= busy_d;
        end
    end

    // Registered read ports and busy summary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData1_q <= '0;
            readData2_q <= '0;
            readBusy1_q <= 1'b0;
            readBusy2_q <= 1'b0;
            anyBusy_q   <= 1'b0;
        end else begin
            readData1_q <= readData1_d;
            readData2_q <= readData2_d;
            readBusy1_q <= readBusy1_d;
            readBusy2_q <= readBusy2_d;
            anyBusy_q   <= anyBusy_d;
        end
    end

    assign ReadData1 = readData1_q;
    assign ReadData2 = readData2_q;
    assign ReadBusy1 = readBusy1_q;
    assign ReadBusy2 = readBusy2_q;
    assign AnyBusy   = anyBusy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance (hardwired r0), a twin
// with ZERO_REG=0 on the same stimulus, and a 16-bit x 8-entry instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;

    // Shared stimulus for the two 32x32 instances
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        SetBusy;
    logic [4:0]  SetBusyRegister;
    logic [4:0]  ReadRegister1, ReadRegister2;

    logic [31:0] aRd1, aRd2, bRd1, bRd2;
    logic        aRb1, aRb2, aAny, bRb1, bRb2, bAny;

    // Stimulus for the 16x8 instance
    logic        cRegWrite;
    logic [2:0]  cWriteRegister;
    logic [15:0] cWriteData;
    logic        cSetBusy;
    logic [2:0]  cSetBusyRegister;
    logic [2:0]  cReadRegister1, cReadRegister2;
    logic [15:0] cRd1, cRd2;
    logic        cRb1, cRb2, cAny;

    int nVectors = 0;
    int nMiss    = 0;

    typedef struct {
        logic        regWrite;
        logic [4:0]  wrReg;
        logic [31:0] wrData;
        logic        setBusy;
        logic [4:0]  sbReg;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] aRd1;
        logic [31:0] aRd2;
        logic        aRb1;
        logic        aRb2;
        logic        aAny;
        logic [31:0] bRd1;
        logic [31:0] bRd2;
        logic        bRb1;
        logic        bRb2;
        logic        bAny;
    } vec_t;

    vec_t vecs [14];

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    regfile_scoreboard dutA (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .SetBusy(SetBusy), .SetBusyRegister(SetBusyRegister),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(aRd1), .ReadData2(aRd2),
        .ReadBusy1(aRb1), .ReadBusy2(aRb2), .AnyBusy(aAny)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dutB (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .SetBusy(SetBusy), .SetBusyRegister(SetBusyRegister),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(bRd1), .ReadData2(bRd2),
        .ReadBusy1(bRb1), .ReadBusy2(bRb2), .AnyBusy(bAny)
    );

    regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dutC (
        .clk(clk), .reset(reset),
        .RegWrite(cRegWrite), .WriteRegister(cWriteRegister), .WriteData(cWriteData),
        .SetBusy(cSetBusy), .SetBusyRegister(cSetBusyRegister),
        .ReadRegister1(cReadRegister1), .ReadRegister2(cReadRegister2),
        .ReadData1(cRd1), .ReadData2(cRd2),
        .ReadBusy1(cRb1), .ReadBusy2(cRb2), .AnyBusy(cAny)
    );

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one table entry, clock it in, then compare both 32-bit instances
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        RegWrite        = v.regWrite;
        WriteRegister   = v.wrReg;
        WriteData       = v.wrData;
        SetBusy         = v.setBusy;
        SetBusyRegister = v.sbReg;
        ReadRegister1   = v.rr1;
        ReadRegister2   = v.rr2;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        SetBusy  = 1'b0;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, " A.ReadData1"}, aRd1, v.aRd1);
        checkOutput({tag, " A.ReadData2"}, aRd2, v.aRd2);
        checkOutput({tag, " A.ReadBusy1"}, {31'b0, aRb1}, {31'b0, v.aRb1});
        checkOutput({tag, " A.ReadBusy2"}, {31'b0, aRb2}, {31'b0, v.aRb2});
        checkOutput({tag, " A.AnyBusy"},   {31'b0, aAny}, {31'b0, v.aAny});
        checkOutput({tag, " B.ReadData1"}, bRd1, v.bRd1);
        checkOutput({tag, " B.ReadData2"}, bRd2, v.bRd2);
        checkOutput({tag, " B.ReadBusy1"}, {31'b0, bRb1}, {31'b0, v.bRb1});
        checkOutput({tag, " B.ReadBusy2"}, {31'b0, bRb2}, {31'b0, v.bRb2});
        checkOutput({tag, " B.AnyBusy"},   {31'b0, bAny}, {31'b0, v.bAny});
    endtask

    // Idle an edge on the 16-bit instance with the given write/read request
    task automatic stepC(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        cRegWrite      = we;
        cWriteRegister = wr;
        cWriteData     = wd;
        cReadRegister1 = r1;
        cReadRegister2 = r2;
        @(posedge clk);
        #1;
        cRegWrite = 1'b0;
    endtask

    initial begin
        // Fields: we, wr, wdata, sb, sbReg, rr1, rr2 | A: rd1, rd2, rb1, rb2, any | B: rd1, rd2, rb1, rb2, any
        vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,
                     32'h0,        32'h0,        1'b0, 1'b0, 1'b0,
                     32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,
                     32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0,
                     32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd9,  32'hCAFEF00D, 1'b0, 5'd0,  5'd9,  5'd9,
                     32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0,
                     32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd9,
                     32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b1,
                     32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd4,  32'h1,        1'b0, 5'd0,  5'd4,  5'd4,
                     32'h1,        32'h1,        1'b0, 1'b0, 1'b0,
                     32'h1,        32'h1,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd4,  32'h2,        1'b1, 5'd4,  5'd4,  5'd7,
                     32'h2,        32'h12345678, 1'b1, 1'b0, 1'b1,
                     32'h2,        32'h12345678, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd4,  5'd10,
                     32'h2,        32'h0,        1'b1, 1'b1, 1'b1,
                     32'h2,        32'h0,        1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 5'd10, 32'hAAAA5555, 1'b0, 5'd0,  5'd10, 5'd4,
                     32'hAAAA5555, 32'h2,        1'b0, 1'b1, 1'b1,
                     32'hAAAA5555, 32'h2,        1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'd4,  32'h3,        1'b0, 5'd0,  5'd4,  5'd10,
                     32'h3,        32'hAAAA5555, 1'b0, 1'b0, 1'b0,
                     32'h3,        32'hAAAA5555, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,
                     32'h0,        32'h0,        1'b0, 1'b0, 1'b0,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,
                     32'h0,        32'h0,        1'b0, 1'b0, 1'b0,
                     32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd7,
                     32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0,
                     32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd5,
                     32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0,
                     32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  5'd5,  5'd6,
                     32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1,
                     32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1};

        reset           = 1'b1;
        RegWrite        = 1'b0;
        WriteRegister   = '0;
        WriteData       = '0;
        SetBusy         = 1'b0;
        SetBusyRegister = '0;
        ReadRegister1   = '0;
        ReadRegister2   = '0;
        cRegWrite        = 1'b0;
        cWriteRegister   = '0;
        cWriteData       = '0;
        cSetBusy         = 1'b0;
        cSetBusyRegister = '0;
        cReadRegister1   = '0;
        cReadRegister2   = '0;

        // Reset state, held across an edge
        @(posedge clk);
        #1;
        checkOutput("reset ReadData1", aRd1, 32'h0);
        checkOutput("reset ReadData2", aRd2, 32'h0);
        checkOutput("reset AnyBusy",   {31'b0, aAny}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset between edges: r5 holds DEADBEEF, r6 is busy
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async ReadData1", aRd1, 32'h0);
        checkOutput("async ReadBusy2", {31'b0, aRb2}, 32'h0);
        checkOutput("async AnyBusy",   {31'b0, aAny}, 32'h0);
        checkOutput("async B.AnyBusy", {31'b0, bAny}, 32'h0);
        #1;
        reset = 1'b0;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd6;
        @(posedge clk);
        #1;
        checkOutput("post-reset r5",      aRd1, 32'h0);
        checkOutput("post-reset r6 busy", {31'b0, aRb2}, 32'h0);
        checkOutput("post-reset AnyBusy", {31'b0, aAny}, 32'h0);

        // 16-bit x 8 instance: write index*0x1111, bypass read plus a look-ahead read
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  idx;
            logic [2:0]  nxt;
            logic [15:0] val;
            idx = 3'(i);
            nxt = 3'(i + 1);
            val = 16'(i * 16'h1111);
            stepC(1'b1, idx, val, idx, nxt);
            checkOutput($sformatf("C bypass r%0d", i), {16'b0, cRd1}, {16'b0, val});
            checkOutput($sformatf("C ahead r%0d", (i + 1) % 8), {16'b0, cRd2}, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            logic [2:0] mir;
            idx = 3'(i);
            mir = 3'(7 - i);
            stepC(1'b0, 3'd0, 16'h0, idx, mir);
            checkOutput($sformatf("C read r%0d", i), {16'b0, cRd1}, 32'(i * 32'h1111));
            checkOutput($sformatf("C read r%0d", 7 - i), {16'b0, cRd2}, 32'((7 - i) * 32'h1111));
        end
        checkOutput("C AnyBusy", {31'b0, cAny}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
